// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable, select and ALUop.
module mc_main_ctrl #(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done
);

  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RCOMP   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDI_EX = 4'd10;
  localparam logic [3:0] S_ADDI_WB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_rdy;
  logic       w_opLegal;
  logic       w_unused;

  // The zero flag is consumed by the datapath's PC-write gating, not by the sequencer.
  assign w_unused = zero;

  assign w_rdy = mem_ready | ~MEM_WAIT_EN;
  assign state = r_state;

  always_comb begin
    w_opLegal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_opLegal = 1'b1;
      default:                                       w_opLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:      w_next = w_rdy ? S_ID : S_IF;
      S_ID: begin
        case (op)
          OP_RTYPE:      w_next = S_EXEC;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ:        w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI:       w_next = S_ADDI_EX;
          default:       w_next = S_IF;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_IF;
      S_MEMWR:   w_next = w_rdy ? S_IF : S_MEMWR;
      S_EXEC:    w_next = S_RCOMP;
      S_RCOMP:   w_next = S_IF;
      S_BRANCH:  w_next = S_IF;
      S_JUMP:    w_next = S_IF;
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_ADDI_WB: w_next = S_IF;
      default:   w_next = S_IF;
    endcase
  end

  // Moore decode of the state; only the memory-facing states look at rdy.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_rdy;
        pc_write  = w_rdy;
      end
      S_ID: begin
        alu_src_b  = 2'b11;
        instr_done = ~w_opLegal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = w_rdy;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
      end
      S_RCOMP: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        alu_src_b = 2'b00;
      end
    endcase

    // Reset holds the state at IF, but the enables must not fire while it is asserted.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule
